// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared definitions for the digit-serial adder: the control
//               FSM state encoding and the digit-counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    // Control FSM states, 2-bit explicit encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // ceil(log2(n)) with a floor of 1 so a single-digit adder still gets a
    // legal one-bit counter.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/digit_adder.sv
`default_nettype none
// ============================================================================
// Module      : digit_adder
// Description : Combinational DIGIT-bit full adder used once per cycle by
//               the serial adder.
// Ports       : x, y  - DIGIT-bit addend digits
//               ci    - carry in
//               s     - DIGIT-bit digit sum
//               co    - carry out of the digit MSB
// Revision    : 1.0 - initial release
// ============================================================================
module digit_adder
    import serial_adder_pkg::*;
#(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co
);

    logic [DIGIT:0] w_total;

    assign w_total = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};
    assign s       = w_total[DIGIT-1:0];
    assign co      = w_total[DIGIT];

endmodule : digit_adder
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Digit-serial unsigned adder. Operands are captured on a
//               valid/ready handshake, added DIGIT bits per cycle LSB first,
//               and the result {cout,sum} = a + b + cin is held until taken.
// Parameters  : WIDTH   - operand/result width (multiple of DIGIT)
//               DIGIT   - bits added per cycle
//               USE_CIN - 1: full add with cin, 0: cin ignored
// Ports       : clk, rst           - clock, synchronous active-high reset
//               in_valid/in_ready  - operand handshake (ready only in IDLE)
//               a, b, cin          - operands and carry-in
//               out_valid/out_ready- result handshake (valid only in DONE)
//               sum, cout          - result and carry out of the MSB
//               ovf                - signed overflow (SERIAL_ADDER_OVF_EN only)
// Options     : define SERIAL_ADDER_OVF_EN to add the ovf output.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DIGIT   = 2,
    parameter int USE_CIN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int c_num_digits = WIDTH / DIGIT;
    localparam int c_cnt_w      = cnt_width(c_num_digits);
    localparam logic [c_cnt_w-1:0] c_last_digit = c_cnt_w'(c_num_digits - 1);

    state_t             state_q, state_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic               w_cin_eff;
    logic [DIGIT-1:0]   w_x;
    logic [DIGIT-1:0]   w_y;
    logic [DIGIT-1:0]   w_s;
    logic               w_co;
    logic               w_last;

    // ------------------------------------------------------------------
    // Carry-in selection is fixed at elaboration time.
    // ------------------------------------------------------------------
    generate
        if (USE_CIN != 0) begin : g_full_add
            assign w_cin_eff = cin;
        end else begin : g_half_add
            logic w_unused_cin;
            assign w_unused_cin = cin;
            assign w_cin_eff    = 1'b0;
        end
    endgenerate

    assign w_last = (cnt_q == c_last_digit);

    // Select the current operand digit with constant slices so that no
    // variable part-select is needed.
    always_comb begin
        w_x = '0;
        w_y = '0;
        for (int i = 0; i < c_num_digits; i++) begin
            if (cnt_q == c_cnt_w'(i)) begin
                w_x = a_q[i*DIGIT +: DIGIT];
                w_y = b_q[i*DIGIT +: DIGIT];
            end
        end
    end

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .x  (w_x),
        .y  (w_y),
        .ci (carry_q),
        .s  (w_s),
        .co (w_co)
    );

    // ------------------------------------------------------------------
    // State register (plus datapath registers)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (w_last)    state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        if (state_q == IDLE) begin
            if (in_valid) begin
                a_d     = a;
                b_d     = b;
                carry_d = w_cin_eff;
                cnt_d   = '0;
            end
        end else if (state_q == RUN) begin
            for (int i = 0; i < c_num_digits; i++) begin
                if (cnt_q == c_cnt_w'(i)) begin
                    sum_d[i*DIGIT +: DIGIT] = w_s;
                end
            end
            carry_d = w_co;
            if (w_last) begin
                cnt_d  = '0;
                cout_d = w_co;
`ifdef SERIAL_ADDER_OVF_EN
                // Carry into the MSB is recovered from the MSB sum bit:
                // c_msb = a_msb ^ b_msb ^ s_msb.
                ovf_d  = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ w_s[DIGIT-1] ^ w_co;
`endif
            end else begin
                cnt_d  = cnt_q + c_cnt_w'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule : serial_adder
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Self-checking bench for serial_adder. Four configurations
//               run side by side: (8,2,cin), (8,2,no cin), (16,16), (16,1).
//               A transaction-level model predicts ready/valid timing and
//               the arithmetic result; literal cases pin known answers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  in_valid_i, out_ready_i, cin_i;
    logic [15:0] a_i [4];
    logic [15:0] b_i [4];
    logic [3:0]  in_ready_o, out_valid_o, cout_o;
    logic [7:0]  sum0, sum1;
    logic [15:0] sum2, sum3;
`ifdef SERIAL_ADDER_OVF_EN
    logic [3:0]  ovf_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    serial_adder #(.WIDTH(8), .DIGIT(2), .USE_CIN(1)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid_i[0]), .in_ready(in_ready_o[0]),
        .a(a_i[0][7:0]), .b(b_i[0][7:0]), .cin(cin_i[0]), .out_valid(out_valid_o[0]),
        .out_ready(out_ready_i[0]), .sum(sum0), .cout(cout_o[0])
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf_o[0])
`endif
    );
    serial_adder #(.WIDTH(8), .DIGIT(2), .USE_CIN(0)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_i[1]), .in_ready(in_ready_o[1]),
        .a(a_i[1][7:0]), .b(b_i[1][7:0]), .cin(cin_i[1]), .out_valid(out_valid_o[1]),
        .out_ready(out_ready_i[1]), .sum(sum1), .cout(cout_o[1])
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf_o[1])
`endif
    );
    serial_adder #(.WIDTH(16), .DIGIT(16), .USE_CIN(1)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid_i[2]), .in_ready(in_ready_o[2]),
        .a(a_i[2]), .b(b_i[2]), .cin(cin_i[2]), .out_valid(out_valid_o[2]),
        .out_ready(out_ready_i[2]), .sum(sum2), .cout(cout_o[2])
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf_o[2])
`endif
    );
    serial_adder #(.WIDTH(16), .DIGIT(1), .USE_CIN(1)) u3 (
        .clk(clk), .rst(rst), .in_valid(in_valid_i[3]), .in_ready(in_ready_o[3]),
        .a(a_i[3]), .b(b_i[3]), .cin(cin_i[3]), .out_valid(out_valid_o[3]),
        .out_ready(out_ready_i[3]), .sum(sum3), .cout(cout_o[3])
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf_o[3])
`endif
    );

    // Configuration table of the four instances.
    function automatic int w_of(input int k);
        return (k < 2) ? 8 : 16;
    endfunction
    function automatic int n_of(input int k);
        case (k)
            0, 1:    return 4;
            2:       return 1;
            default: return 16;
        endcase
    endfunction
    function automatic bit uc_of(input int k);
        return (k != 1);
    endfunction
    function automatic logic [15:0] get_sum(input int k);
        case (k)
            0:       return {8'h00, sum0};
            1:       return {8'h00, sum1};
            2:       return sum2;
            default: return sum3;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction model: phase -1 = idle, >0 = edges left until result,
    // 0 = result presented.
    // ------------------------------------------------------------------
    int          phase   [4];
    logic [15:0] exp_sum [4];
    logic        exp_cout[4];
    logic        exp_ovf [4];
    int          accepts [4];
    bit          chk_en = 0;

    initial begin
        for (int k = 0; k < 4; k++) begin
            phase[k]   = -1;
            accepts[k] = 0;
        end
    end

    always @(posedge clk) begin
        if (rst) chk_en = 1;
        for (int k = 0; k < 4; k++) begin
            if (rst) begin
                phase[k] = -1;
            end else if (phase[k] == -1) begin
                if (in_valid_i[k]) begin
                    longint m, sa, sb, c, r, tot, half;
                    m  = (longint'(1) << w_of(k)) - 1;
                    c  = (uc_of(k) && cin_i[k]) ? 1 : 0;
                    sa = longint'(a_i[k]) & m;
                    sb = longint'(b_i[k]) & m;
                    r  = sa + sb + c;
                    exp_sum[k]  = 16'(r & m);
                    exp_cout[k] = ((r >> w_of(k)) & 1) != 0;
                    half = (m + 1) / 2;
                    if (sa >= half) sa = sa - (m + 1);
                    if (sb >= half) sb = sb - (m + 1);
                    tot = sa + sb + c;
                    exp_ovf[k] = (tot >= half) || (tot < -half);
                    phase[k]   = n_of(k);
                    accepts[k]++;
                end
            end else if (phase[k] > 0) begin
                phase[k]--;
            end else if (out_ready_i[k]) begin
                phase[k] = -1;
            end
        end
    end

    // Cycle-by-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 4; k++) begin
                bit ok;
                ok = (in_ready_o[k] === (phase[k] == -1)) &&
                     (out_valid_o[k] === (phase[k] == 0));
                if (phase[k] == 0) begin
                    ok = ok && (get_sum(k) === exp_sum[k]) && (cout_o[k] === exp_cout[k]);
`ifdef SERIAL_ADDER_OVF_EN
                    ok = ok && (ovf_o[k] === exp_ovf[k]);
`endif
                end
                n_tests++;
                if (!ok) begin
                    n_fail++;
                    $display("FAIL model d%0d t=%0t: rdy=%b vld=%b sum=0x%0h cout=%b, expected rdy=%b vld=%b sum=0x%0h cout=%b",
                             k, $time, in_ready_o[k], out_valid_o[k], get_sum(k), cout_o[k],
                             phase[k] == -1, phase[k] == 0, exp_sum[k], exp_cout[k]);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed operation with literal expectations.
    // ------------------------------------------------------------------
    task automatic run_op(input int k, input logic [15:0] a, input logic [15:0] b, input logic c,
                          input logic [15:0] es, input logic ec, input int hold);
        int lat;
        int guard;
        guard = 0;
        while (!in_ready_o[k] && guard < 50) begin
            @(posedge clk); #2; guard++;
        end
        check($sformatf("d%0d ready before op", k), in_ready_o[k], 1);
        a_i[k] = a; b_i[k] = b; cin_i[k] = c; in_valid_i[k] = 1'b1;
        @(posedge clk); #2;
        in_valid_i[k] = 1'b0;
        lat = 0;
        while (!out_valid_o[k] && lat < 100) begin
            @(posedge clk); #2; lat++;
        end
        check($sformatf("d%0d latency", k), lat, n_of(k));
        for (int h = 0; h < hold; h++) begin
            a_i[k] = 16'($urandom); b_i[k] = 16'($urandom);
            in_valid_i[k] = 1'($urandom_range(0, 1));
            @(posedge clk); #2;
            check($sformatf("d%0d hold in_ready", k), in_ready_o[k], 0);
        end
        check($sformatf("d%0d sum", k), get_sum(k), es);
        check($sformatf("d%0d cout", k), cout_o[k], ec);
        check($sformatf("d%0d out_valid held", k), out_valid_o[k], 1);
        in_valid_i[k] = 1'b0; out_ready_i[k] = 1'b1;
        @(posedge clk); #2;
        out_ready_i[k] = 1'b0;
        check($sformatf("d%0d released", k), {in_ready_o[k], out_valid_o[k]}, 2'b10);
    endtask

    initial begin
        int base [4];
        int cyc;
        bit done;
        rst = 1'b1;
        in_valid_i = '0; out_ready_i = '0; cin_i = '0;
        for (int k = 0; k < 4; k++) begin a_i[k] = '0; b_i[k] = '0; end
        repeat (2) @(posedge clk);
        #2;
        check("reset ready/valid", {in_ready_o, out_valid_o}, 8'hF0);
        check("reset sums", {sum0, sum1, sum2, sum3}, 48'h0);
        check("reset cout", cout_o, 4'h0);
        rst = 1'b0;

        run_op(0, 16'h00FF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0);
        run_op(0, 16'h007F, 16'h0000, 1'b1, 16'h0080, 1'b0, 0);
`ifdef SERIAL_ADDER_OVF_EN
        check("d0 ovf 7F+0+1", ovf_o[0], 1);
`endif
        run_op(1, 16'h0010, 16'h0020, 1'b1, 16'h0030, 1'b0, 0);
        run_op(0, 16'h0012, 16'h0034, 1'b0, 16'h0046, 1'b0, 5);
        run_op(2, 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1, 0);
        run_op(3, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 2);

        // Reset on the second RUN cycle discards the operation.
        a_i[0] = 16'h00FF; b_i[0] = 16'h0001; cin_i[0] = 1'b0; in_valid_i[0] = 1'b1;
        @(posedge clk); #2;
        in_valid_i[0] = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        check("rst mid-run ready/valid", {in_ready_o[0], out_valid_o[0]}, 2'b10);
        check("rst mid-run sum", sum0, 8'h00);
        run_op(0, 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 0);

        // Random traffic on all instances, checked by the model.
        for (int k = 0; k < 4; k++) base[k] = accepts[k];
        done = 0;
        for (cyc = 0; cyc < 20000 && !done; cyc++) begin
            @(posedge clk); #2;
            for (int k = 0; k < 4; k++) begin
                in_valid_i[k]  = 1'($urandom_range(0, 1));
                out_ready_i[k] = 1'($urandom_range(0, 1));
                cin_i[k]       = 1'($urandom_range(0, 1));
                a_i[k] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
                b_i[k] = 16'($urandom);
            end
            done = 1;
            for (int k = 0; k < 4; k++) if (accepts[k] - base[k] < 200) done = 0;
        end
        check("random ops completed", done, 1);

        in_valid_i = '0; out_ready_i = '1;
        repeat (20) @(posedge clk);
        #2;
        check("drain idle", {in_ready_o, out_valid_o}, 8'hF0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_serial_adder
`default_nettype wire
